// File: rtl/sar_adc_ctrl_if.sv
// Signal bundle between a SAR ADC controller and its user / analog front end.
// The slave modport is the controller; the master side requests conversions and supplies the comparator.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic             sample_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    output start, cmp_in,
    input  dac_code, sample_en, busy, done, result, result_valid
  );

  modport slave (
    input  start, cmp_in,
    output dac_code, sample_en, busy, done, result, result_valid
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: samples, then resolves one bit per trial MSB first
// against an external R-2R DAC and an asynchronous comparator.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  sar_adc_ctrl_if.slave bus
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES - 1 : SETTLE_CYCLES - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BIT_W-1:0]   bit_idx, bit_idx_n;
  logic [WIDTH-1:0]   sar, sar_n;
  logic [WIDTH-1:0]   result_q, result_n;
  logic               valid_q, valid_n;
  logic               cmp_meta, cmp_s;

  // cmp_in is only ever seen through the two-flop synchroniser; the settle time absorbs its latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sar      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      sar      <= sar_n;
      result_q <= result_n;
      valid_q  <= valid_n;
      cmp_meta <= bus.cmp_in;
      cmp_s    <= cmp_meta;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    bit_idx_n     = bit_idx;
    sar_n         = sar;
    result_n      = result_q;
    valid_n       = valid_q;
    bus.dac_code  = '0;
    bus.sample_en = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;

    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_n = SAMPLE;
          cnt_n   = CNT_W'(SAMPLE_CYCLES - 1);
          sar_n   = '0;
        end
      end

      SAMPLE: begin
        bus.sample_en = 1'b1;
        if (cnt == '0) begin
          state_n   = TRIAL;
          bit_idx_n = BIT_W'(WIDTH - 1);
          cnt_n     = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      // The trial code is held for the whole settle window; the decision lands on its last cycle.
      TRIAL: begin
        bus.dac_code = sar | (WIDTH'(1) << bit_idx);
        if (cnt == '0) begin
          sar_n[bit_idx] = cmp_s;
          cnt_n          = CNT_W'(SETTLE_CYCLES - 1);
          if (bit_idx == '0) begin
            state_n  = DONE;
            result_n = sar_n;
            valid_n  = 1'b1;
          end else begin
            bit_idx_n = bit_idx - BIT_W'(1);
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      DONE: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
- Digital controller for the successive-approximation ADC on the analog study tile.
- Drives an external R-2R DAC through `dac_code`, which maps to the `uo_out` pins, and asserts `sample_en` for the track/hold switch.
- Reads the asynchronous analog comparator output, which arrives on `ui_in[0]`.
- Resolves one bit per trial, MSB first, and presents a `WIDTH`-bit result with a done pulse.

Parameters:
- `WIDTH`, 8: conversion resolution in bits; `dac_code` and `result` width; legal range 2..8.
- `SAMPLE_CYCLES`, 8: cycles `sample_en` is held high per conversion; minimum 1.
- `SETTLE_CYCLES`, 4: cycles each trial code is held before the decision; includes the 2-cycle comparator synchroniser; minimum 3.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: conversion request; sampled only in IDLE.
- `cmp_in` input 1: asynchronous comparator output; 1 means Vin >= Vdac.
- `dac_code` output `WIDTH`: trial code to the external R-2R DAC.
- `sample_en` output 1: track/hold switch enable; high during the SAMPLE state.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: single-cycle pulse when `result` is updated.
- `result` output `WIDTH`: last completed conversion; holds until the next conversion completes.
- `result_valid` output 1: set when a conversion completes; cleared on reset only.

Behaviour:
- Reset, synchronous on a `clk` edge with `rst`=1:
  - state = IDLE.
  - `dac_code`=0, `sample_en`=0, `busy`=0, `done`=0, `result`=0, `result_valid`=0.
  - Synchroniser flops = 0; all counters = 0.
  - Reset has priority over every other event, including mid-conversion. A conversion interrupted by reset is discarded and `result` returns to 0.
- Comparator input: passes through a 2-flop synchroniser; `cmp_s` is the second-flop output. No other logic reads `cmp_in` directly.
- State machine: IDLE, SAMPLE, TRIAL, DONE.
- IDLE:
  - `dac_code`=0.
  - `start`=1 → SAMPLE on the next cycle. Cycle counter loads `SAMPLE_CYCLES`-1; the internal approximation register `sar` clears to 0.
- SAMPLE:
  - `sample_en`=1, `busy`=1, `dac_code`=0.
  - Counter decrements each cycle; at 0 → TRIAL with bit index k=`WIDTH`-1, and the counter loads `SETTLE_CYCLES`-1.
  - `sample_en` is high for exactly `SAMPLE_CYCLES` cycles.
- TRIAL, bit k:
  - `dac_code` = `sar` with bit k forced to 1, held for exactly `SETTLE_CYCLES` cycles.
  - On the cycle the counter is 0, `sar`[k] is set to `cmp_s`.
  - If k>0: k decrements, the counter reloads, and TRIAL stays.
  - If k=0 → DONE.
- DONE, one cycle:
  - `done`=1, `result` = final `sar`, `result_valid`=1, `dac_code`=0.
  - → IDLE next cycle. `busy` is 1 in DONE and 0 in the following cycle.
- Latency: with `start` accepted in cycle 0, `done` is high in cycle 1+`SAMPLE_CYCLES`+`WIDTH`*`SETTLE_CYCLES`. Defaults give cycle 41.
- `start` while `busy`=1 (including the DONE cycle) is ignored; no queueing.
- `start` held high continuously gives back-to-back conversions separated by exactly one IDLE cycle.
- Arithmetic:
  - The result is unsigned binary; no saturation logic is needed.
  - Vin at or above full-scale gives all ones; Vin below 1 LSB gives 0.
  - `dac_code` changes only at state or bit boundaries, never mid-trial.

Test Plan:
- Comparator model (`cmp_in` = vin_code >= `dac_code`, combinational), vin_code=0xA5, pulse `start` → `done` at cycle 41; `result`=0xA5; `result_valid`=1; `dac_code` trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held 4 cycles.
- vin_code=0x00, then 0xFF, then 0x80 → `result` 0x00, 0xFF, 0x80 respectively; `sample_en` high exactly 8 cycles per conversion.
- `start` pulsed at cycles 5, 20 and 41 of a conversion → ignored; exactly one `done` pulse; `busy` drops in cycle 42.
- `rst` asserted at cycle 25 of a conversion → next cycle all outputs 0 and state IDLE; a fresh `start` converts correctly with the full 41-cycle latency.
- `start` held high, vin_code alternating 0x3C/0xC3 per conversion → `done` pulses every 42 cycles; results 0x3C, 0xC3, 0x3C; `result` stable between pulses.
- `WIDTH`=4, `SETTLE_CYCLES`=3, `SAMPLE_CYCLES`=1, vin_code=0x9 → `done` at cycle 1+1+12=14; `result`=0x9.
